// File: rtl/usr_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : usr_shift_sequencer
// Description : Command-driven sequencer that serializes or deserializes a word
//               through an external universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_shift_sequencer #(
    parameter int WIDTH     = 4,
    parameter int SHIFT_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_in_take,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_p_din,
    output logic             usr_s_left_din,
    output logic             usr_s_right_din,
    input  logic [WIDTH-1:0] usr_p_dout,
    input  logic             usr_s_left_dout,
    input  logic             usr_s_right_dout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(SHIFT_GAP + 2);

    localparam logic [CW-1:0] c_LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] c_GAP_LAST = GW'((SHIFT_GAP > 0) ? SHIFT_GAP - 1 : 0);

    localparam logic [1:0] c_SEL_HOLD  = 2'b00;
    localparam logic [1:0] c_SEL_RIGHT = 2'b01;
    localparam logic [1:0] c_SEL_LEFT  = 2'b10;
    localparam logic [1:0] c_SEL_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mode;
    logic              r_dir;
    logic [WIDTH-1:0]  r_data;
    logic [CW-1:0]     r_bit_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              w_shift_last;

    assign w_shift_last = (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_dir     <= 1'b0;
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cmd_valid) begin
                r_mode <= cmd_mode;
                r_dir  <= cmd_dir;
                r_data <= cmd_data;
            end
            if (w_next == S_LOAD) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT && !abort) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            // The gap counter restarts on every shift so each GAP visit lasts SHIFT_GAP cycles.
            if (r_state == S_SHIFT) begin
                r_gap_cnt <= '0;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        cmd_ready       = 1'b0;
        usr_select      = c_SEL_HOLD;
        usr_p_din       = '0;
        usr_s_left_din  = 1'b0;
        usr_s_right_din = 1'b0;
        ser_out         = 1'b0;
        ser_out_valid   = 1'b0;
        ser_in_take     = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    usr_select = c_SEL_LOAD;
                    usr_p_din  = r_data;
                    w_next     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    usr_select = r_dir ? c_SEL_LEFT : c_SEL_RIGHT;
                    if (r_mode) begin
                        ser_in_take = 1'b1;
                        if (r_dir) begin
                            usr_s_right_din = ser_in;
                        end else begin
                            usr_s_left_din = ser_in;
                        end
                    end else begin
                        ser_out_valid = 1'b1;
                        ser_out       = r_dir ? usr_s_left_dout : usr_s_right_dout;
                    end
                    if (w_shift_last) begin
                        w_next = S_DONE;
                    end else if (SHIFT_GAP > 0) begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_next = S_SHIFT;
                end
            end
            S_DONE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    rsp_valid = 1'b1;
                    rsp_data  = usr_p_dout;
                    if (rsp_ready) begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
